// File: rtl/bucket_pkg.sv
// Shared definitions for the bucket accumulation path.
// Holds the bucket geometry, the weight-code limits, the mapping from
// bucket index to power-of-two weight (shared with the score adder) and
// the accumulator state enum.
package bucket_pkg;

   localparam int N_BUCKETS     = 13;
   localparam int CNT_W         = 8;
   localparam int CODE_W        = 4;
   localparam int ZERO_CODE_MIN = 13;   // codes at or above this carry zero weight

   // Buckets 0..4 hold negative weights, buckets 5..12 positive weights.
   localparam int N_NEG_BUCKETS = 5;
   localparam int N_POS_BUCKETS = N_BUCKETS - N_NEG_BUCKETS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Weight sign of a bucket: 1 = negative.
   function automatic logic bucket_is_negative(input int idx);
      return (idx < N_NEG_BUCKETS);
   endfunction

   // Power-of-two exponent of a bucket's weight magnitude.
   // Negative buckets 0..4 -> 2^0..2^4, positive buckets 5..12 -> 2^0..2^7.
   function automatic int bucket_shift(input int idx);
      return (idx < N_NEG_BUCKETS) ? idx : (idx - N_NEG_BUCKETS);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for one weight bucket.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : increment request
//   count      : current count, saturates at 2^W-1
//   sat_hit    : increment requested while already at the maximum
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sat_hit
);

   localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

   logic at_max;

   assign at_max  = (count == MAX_VAL);
   assign sat_hit = inc & at_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/bucket_count_accumulator.sv
// Per-neuron bucket counter: consumes N_INPUTS (pixel, weight code) items
// and counts active pixels per weight code into N_BUCKETS saturating counters.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : one-cycle pulse, begins an accumulation (IDLE only)
//   in_valid/in_ready    : item stream handshake
//   in_pixel, in_code    : item payload (code >= 13 means zero weight)
//   out_valid/out_ready  : result handshake
//   out_val              : bucket counts, index 0..12
//   busy                 : not IDLE
//   sat                  : some bucket saturated during this neuron (sticky)
module bucket_count_accumulator
   import bucket_pkg::*;
#(
   parameter int N_INPUTS = 784
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_pixel,
   input  logic [CODE_W-1:0]                 in_code,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [N_BUCKETS-1:0][CNT_W-1:0]   out_val,
   output logic                              busy,
   output logic                              sat
);

   localparam int                ITEM_W    = $clog2(N_INPUTS);
   localparam logic [ITEM_W-1:0] LAST_ITEM = ITEM_W'(N_INPUTS - 1);

   state_t               state_reg, state_next;
   logic [ITEM_W-1:0]    item_reg;
   logic                 sat_reg;
   logic                 clr;
   logic                 accept;
   logic                 weighted;
   logic [N_BUCKETS-1:0] inc;
   logic [N_BUCKETS-1:0] sat_hit;

   assign accept   = in_valid & in_ready;
   // Only active pixels with a non-zero-weight code reach a bucket.
   assign weighted = accept & in_pixel & (in_code < CODE_W'(ZERO_CODE_MIN));

   // One-hot decoded increment: at most one bucket moves per cycle.
   // The bucket registers themselves drive out_val, so the result is
   // complete the cycle DONE is entered and holds until the next start.
   generate
      for (genvar gi = 0; gi < N_BUCKETS; gi++) begin : g_bucket
         assign inc[gi] = weighted & (in_code == CODE_W'(gi));

         sat_counter #(
            .W (CNT_W)
         ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .inc     (inc[gi]),
            .count   (out_val[gi]),
            .sat_hit (sat_hit[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      clr        = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            // in_ready stays low here, so an item offered together with
            // start is never consumed.
            if (start) begin
               clr        = 1'b1;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && (item_reg == LAST_ITEM)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         item_reg <= '0;
         sat_reg  <= 1'b0;
      end else if (clr) begin
         item_reg <= '0;
         sat_reg  <= 1'b0;
      end else begin
         if (accept) begin
            item_reg <= item_reg + 1'b1;
         end
         if (|sat_hit) begin
            sat_reg <= 1'b1;
         end
      end
   end

   assign busy = (state_reg != IDLE);
   assign sat  = sat_reg;

endmodule

// File: tb/tb_bucket_count_accumulator.sv
// Self-checking bench for bucket_count_accumulator: randomized streams
// checked against a per-bucket counting model.
module tb_bucket_count_accumulator;
   import bucket_pkg::*;

   localparam int N_IN = 784;

   logic                            clk = 1'b0;
   logic                            rst_n = 1'b0;
   logic                            start = 1'b0;
   logic                            in_valid = 1'b0;
   logic                            in_ready;
   logic                            in_pixel = 1'b0;
   logic [CODE_W-1:0]               in_code = '0;
   logic                            out_valid;
   logic                            out_ready = 1'b0;
   logic [N_BUCKETS-1:0][CNT_W-1:0] out_val;
   logic                            busy;
   logic                            sat;

   int n_tests = 0;
   int n_fail  = 0;

   int model_cnt[N_BUCKETS];
   int model_sat;

   bucket_count_accumulator #(.N_INPUTS(N_IN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pixel  (in_pixel),
      .in_code   (in_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_val   (out_val),
      .busy      (busy),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain per-code counting with a 255 ceiling.
   function automatic void model_clear();
      for (int b = 0; b < N_BUCKETS; b++) model_cnt[b] = 0;
      model_sat = 0;
   endfunction

   function automatic void model_item(input logic p, input int c);
      if (p && c < 13) begin
         if (model_cnt[c] == 255) model_sat = 1;
         else model_cnt[c] = model_cnt[c] + 1;
      end
   endfunction

   // mode 0: all active, code i mod 13
   // mode 1: inactive pixels with any code, or active pixels with codes 13..15
   // mode 2: first 300 active with code 12, the rest inactive
   // mode 3: fully random
   task automatic gen_item(input int mode, input int i, output logic p, output int c);
      case (mode)
         0: begin p = 1'b1; c = i % 13; end
         1: begin
            if ($urandom_range(1) == 0) begin p = 1'b0; c = $urandom_range(15); end
            else begin p = 1'b1; c = 13 + $urandom_range(2); end
         end
         2: begin
            if (i < 300) begin p = 1'b1; c = 12; end
            else begin p = 1'b0; c = $urandom_range(15); end
         end
         default: begin p = 1'($urandom_range(1)); c = $urandom_range(15); end
      endcase
   endtask

   task automatic pulse_start();
      model_clear();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("accum_entry_ready", in_ready, 1);
   endtask

   task automatic stream(input int mode, input int gap_pct, input int start_at,
                         input int abort_at, output int cycles);
      int   i;
      logic p;
      int   c;
      i      = 0;
      cycles = 0;
      while (i < N_IN && cycles < 20000) begin
         if (abort_at >= 0 && i == abort_at) break;
         gen_item(mode, i, p, c);
         in_valid = ($urandom_range(99) >= gap_pct);
         in_pixel = p;
         in_code  = c[CODE_W-1:0];
         start    = (i == start_at);
         if (in_valid && in_ready) begin
            model_item(p, c);
            i++;
         end
         tick();
         cycles++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (abort_at < 0) check("stream_items_accepted", i, N_IN);
   endtask

   task automatic wait_done();
      int w;
      w = 0;
      while (!out_valid && w < 100) begin
         tick();
         w++;
      end
      check("done_reached", out_valid, 1);
   endtask

   task automatic check_counts(input string tag);
      for (int b = 0; b < N_BUCKETS; b++)
         check($sformatf("%s_bucket%0d", tag, b), out_val[b], model_cnt[b]);
      check({tag, "_sat"}, sat, model_sat);
      $display("[TB] %s: b0=%0d b4=%0d b12=%0d sat=%0d", tag, out_val[0], out_val[4],
               out_val[12], sat);
   endtask

   initial begin
      int cyc;
      model_clear();

      // reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_sat", sat, 0);
      for (int b = 0; b < N_BUCKETS; b++) check($sformatf("rst_bucket%0d", b), out_val[b], 0);
      rst_n = 1'b1;
      tick();

      // T1: full stream, code i mod 13; an item offered with start is not consumed
      out_ready = 1'b1;
      model_clear();
      start = 1'b1; in_valid = 1'b1; in_pixel = 1'b1; in_code = 4'd0;
      tick();
      start = 1'b0; in_valid = 1'b0;
      check("t1_accum_entry_ready", in_ready, 1);
      stream(0, 0, -1, -1, cyc);
      check("t1_latency", 1 + cyc, 785);
      check("t1_out_valid", out_valid, 1);
      check("t1_in_ready_done", in_ready, 0);
      check("t1_bucket0_const", out_val[0], 61);
      check("t1_bucket12_const", out_val[12], 60);
      check_counts("t1");
      tick();
      check("t1_done_one_cycle", out_valid, 0);
      check("t1_idle_busy", busy, 0);
      check_counts("t1_held");

      // T2: zero-weight traffic only
      pulse_start();
      stream(1, 10, -1, -1, cyc);
      wait_done();
      check_counts("t2");
      tick();

      // T3: saturation of bucket 12
      pulse_start();
      stream(2, 0, -1, -1, cyc);
      wait_done();
      check("t3_bucket12_const", out_val[12], 255);
      check("t3_sat_const", sat, 1);
      check_counts("t3");
      tick();

      // T4: random gaps, start during ACCUM, out_ready low in DONE with a start
      out_ready = 1'b0;
      pulse_start();
      check("t4_sat_cleared", sat, 0);
      stream(3, 40, 200, -1, cyc);
      wait_done();
      for (int k = 0; k < 10; k++) begin
         start = (k == 5);
         check($sformatf("t4_hold%0d_out_valid", k), out_valid, 1);
         check($sformatf("t4_hold%0d_in_ready", k), in_ready, 0);
         for (int b = 0; b < N_BUCKETS; b++)
            check($sformatf("t4_hold%0d_bucket%0d", k, b), out_val[b], model_cnt[b]);
         tick();
      end
      start = 1'b0;
      check_counts("t4");
      out_ready = 1'b1;
      tick();
      check("t4_released", out_valid, 0);
      check("t4_idle_busy", busy, 0);

      // T5: reset mid-stream at item 400, then a fresh full stream
      pulse_start();
      stream(3, 20, -1, 400, cyc);
      check("t5_mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_in_ready", in_ready, 0);
      check("t5_rst_out_valid", out_valid, 0);
      check("t5_rst_sat", sat, 0);
      for (int b = 0; b < N_BUCKETS; b++) check($sformatf("t5_rst_bucket%0d", b), out_val[b], 0);
      tick();
      rst_n = 1'b1;
      tick();
      pulse_start();
      stream(3, 0, -1, -1, cyc);
      wait_done();
      check_counts("t5");
      tick();
      check("t5_final_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bucket_count_accumulator.md
# bucket_count_accumulator

Sequential front end for the neuron scoring path. It consumes one neuron's input stream of (pixel bit, 4-bit weight code) pairs and counts the active pixels per weight code. It delivers 13 8-bit bucket counts: buckets 0-4 are the negative power-of-two weights and buckets 5-12 are the positive ones. The counts go to the combinational score adder through a valid/ready handshake.

## Interface
- N_INPUTS, 784, stream items per neuron (pixels per image)
- N_BUCKETS, 13, number of weight buckets; fixed by the score adder
- CNT_W, 8, bucket counter width
- CODE_W, 4, weight code width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins one neuron accumulation
- in_valid  in  1  stream item valid
- in_ready  out  1  accumulator accepts an item this cycle
- in_pixel  in  1  binarised pixel (1 = active)
- in_code  in  CODE_W  weight code; 0..12 selects a bucket, 13..15 = zero weight
- out_valid  out  1  bucket counts complete and stable
- out_ready  in  1  consumer takes the counts
- out_val  out  N_BUCKETS x CNT_W  bucket counts, index 0..12
- busy  out  1  state is not IDLE
- sat  out  1  at least one bucket saturated during this neuron

## Operation
- States are IDLE, ACCUM and DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - A start pulse clears all buckets, the item counter and sat, then moves to ACCUM.
- ACCUM:
  - in_ready=1.
  - On a handshake (in_valid & in_ready), the item counter increments.
  - If in_pixel=1 and in_code<13, bucket[in_code] increments, saturating at 255.
  - An attempted increment of a bucket already at 255 sets sat; sat is sticky until the next start.
  - Codes 13..15, or in_pixel=0, change no bucket.
  - The handshake on item N_INPUTS-1 moves to DONE.
- DONE:
  - in_ready=0, out_valid=1, and out_val holds the final counts.
  - out_ready=1 returns to IDLE; out_val keeps its last value until the next start.
- start is ignored in ACCUM and DONE. A start in IDLE is honoured even when in_valid=1 in the same cycle; that item is not consumed.
- Only one bucket changes per cycle, so the bucket update is a single decoded increment.
- Reset (any state, including mid-ACCUM) immediately forces:
  - state IDLE
  - all buckets, item counter and out_val to 0
  - in_ready=0, out_valid=0, busy=0, sat=0
- A partial accumulation is discarded by reset.

## Timing
- start in cycle t gives ACCUM and in_ready=1 in cycle t+1.
- Throughput is one item per cycle. With in_valid held high, the last item is accepted in cycle t+N_INPUTS and out_valid rises in cycle t+N_INPUTS+1.
- Bucket results are registered. out_val reflects every accepted item by the cycle out_valid rises, with no extra pipeline.
- in_valid=0 stalls the accumulation with no state change.
- out_valid stays high until out_ready is sampled high. If out_ready is already high when out_valid rises, DONE lasts exactly one cycle.
- A new start is accepted no earlier than the cycle after the DONE-to-IDLE transition.

## Structure
- Shared package bucket_pkg holds:
  - N_BUCKETS=13, CNT_W=8, CODE_W=4, ZERO_CODE_MIN=13
  - the bucket index-to-weight mapping constants shared with the score adder (0..4 negative, 5..12 positive)
  - the state enum {IDLE, ACCUM, DONE}
- Sub-module sat_counter: a CNT_W-bit counter with clear, increment enable, saturation at 2^CNT_W-1 and a saturate-attempt flag. It is instantiated N_BUCKETS times.
- Item counter width is $clog2(N_INPUTS).

## Test plan
- Reset, then start. Stream 784 items with in_pixel=1 and code = i mod 13 -> bucket 0..3 = 61, bucket 4..12 = 60, sat=0, and out_valid rises 785 cycles after start.
- All pixels 0 with arbitrary codes, plus all pixels 1 with code 13..15 -> out_val all 0.
- 300 active items all with code 12 -> bucket 12 = 255 and sat=1; the other buckets are 0.
- Random in_valid gaps and out_ready held low for 10 cycles after done -> out_val stable, in_ready=0 throughout DONE, and the result matches the software reference count.
- rst_n low mid-stream (item 400), then start and a full stream -> counts reflect only the new stream.
- start pulsed during ACCUM and during DONE -> ignored: no clear and no state change.
